// File: rtl/fma16_pkg.sv
// fma16_pkg: shared constants and types for the fma16 normalize/round back end.
// Contents: rounding-mode encodings, FSM state enum, FP16 format constants.
package fma16_pkg;

    localparam logic [1:0] RZ  = 2'b00;
    localparam logic [1:0] RNE = 2'b01;
    localparam logic [1:0] RM  = 2'b10;
    localparam logic [1:0] RP  = 2'b11;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    localparam logic [7:0]  BIAS    = 8'd15;
    localparam logic [7:0]  EXP_MAX = 8'd31;
    localparam logic [15:0] INF     = 16'h7C00;
    localparam logic [15:0] MAXFIN  = 16'h7BFF;

endpackage

// File: rtl/fma16_normround_if.sv
// fma16_normround_if: operand and result handshakes of the normalize/round back end.
// Signals: in_valid/in_ready with sm, e_in, sign_in, roundmode, in_special, special_res,
//   special_flags; out_valid/out_ready with result and flags {nv, of, uf, nx}.
// Modports: master drives operands and out_ready; slave is the back end itself.
interface fma16_normround_if #(
    parameter int VEC_SIZE = 43
);
    logic                in_valid;
    logic                in_ready;
    logic [VEC_SIZE:0]   sm;
    logic signed [7:0]   e_in;
    logic                sign_in;
    logic [1:0]          roundmode;
    logic                in_special;
    logic [15:0]         special_res;
    logic [3:0]          special_flags;
    logic                out_valid;
    logic                out_ready;
    logic [15:0]         result;
    logic [3:0]          flags;

    modport master (
        output in_valid, sm, e_in, sign_in, roundmode, in_special, special_res, special_flags, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, sm, e_in, sign_in, roundmode, in_special, special_res, special_flags, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fma16_round.sv
// fma16_round: combinational FP16 rounding of a normalized mantissa.
// Ports: m_i (mantissa up to the unit bit), sticky_i (bits lost during normalization),
//   e_i (biased exponent), sign_i, rm_i (rounding mode) -> result_o (FP16), flags_o {of, uf, nx}.
module fma16_round
    import fma16_pkg::*;
#(
    parameter int NORM_POS = 30
) (
    input  logic [NORM_POS:0] m_i,
    input  logic              sticky_i,
    input  logic signed [7:0] e_i,
    input  logic              sign_i,
    input  logic [1:0]        rm_i,
    output logic [15:0]       result_o,
    output logic [2:0]        flags_o
);
    logic [9:0]  frac;
    logic        guard;
    logic        sticky;
    logic        inc;
    logic        of;
    logic        nx;
    logic        uf;
    logic        to_inf;
    logic [7:0]  exp_f;
    logic [17:0] rounded;
    logic [14:0] mag;

    always_comb begin
        frac    = m_i[NORM_POS-1 -: 10];
        guard   = m_i[NORM_POS-11];
        sticky  = |m_i[NORM_POS-12:0] | sticky_i;
        inc     = rm_i == RZ  ? 1'b0 :
                  rm_i == RNE ? guard & (sticky | frac[0]) :
                  rm_i == RM  ? sign_i & (guard | sticky) :
                                ~sign_i & (guard | sticky);
        // A clear unit bit means subnormal; the fraction carry then lands in exponent 1.
        exp_f   = m_i[NORM_POS] ? e_i : 8'd0;
        rounded = {exp_f, frac} + 18'(inc);
        of      = rounded[17:10] >= EXP_MAX;
        nx      = guard | sticky | of;
        uf      = nx & ~m_i[NORM_POS];
        to_inf  = rm_i == RNE || (rm_i == RP && !sign_i) || (rm_i == RM && sign_i);
        mag     = of ? (to_inf ? INF[14:0] : MAXFIN[14:0]) : rounded[14:0];
        result_o = {sign_i, mag};
        flags_o  = {of, uf, nx};
    end
endmodule

// File: rtl/fma16_normround.sv
// fma16_normround: iterative normalize (one bit per cycle) and round back end of fma16.
// Ports: clk; reset (synchronous, active-high); bus (slave modport): operand handshake
//   in_valid/in_ready with sm, e_in, sign_in, roundmode and the in_special bypass,
//   result handshake out_valid/out_ready with result (FP16) and flags {nv, of, uf, nx}.
module fma16_normround
    import fma16_pkg::*;
#(
    parameter int VEC_SIZE = 43,
    parameter int NORM_POS = 30
) (
    input logic              clk,
    input logic              reset,
    fma16_normround_if.slave bus
);
    state_t            state_q;
    logic [VEC_SIZE:0] m_q;
    logic signed [7:0] e_q;
    logic              sticky_q;
    logic              sign_q;
    logic [1:0]        rm_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [15:0]       result_q;
    logic [3:0]        flags_q;
    logic [15:0]       r_res;
    logic [2:0]        r_flags;

    fma16_round #(.NORM_POS(NORM_POS)) u_round (
        .m_i      (m_q[NORM_POS:0]),
        .sticky_i (sticky_q),
        .e_i      (e_q),
        .sign_i   (sign_q),
        .rm_i     (rm_q),
        .result_o (r_res),
        .flags_o  (r_flags)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            m_q         <= '0;
            e_q         <= '0;
            sticky_q    <= 1'b0;
            sign_q      <= 1'b0;
            rm_q        <= RZ;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    m_q        <= bus.sm;
                    e_q        <= bus.e_in;
                    sign_q     <= bus.sign_in;
                    rm_q       <= bus.roundmode;
                    sticky_q   <= 1'b0;
                    in_ready_q <= 1'b0;
                    if (bus.in_special) begin
                        result_q    <= bus.special_res;
                        flags_q     <= bus.special_flags;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (bus.sm == '0) begin
                        result_q    <= {bus.sign_in, 15'b0};
                        flags_q     <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    // Right shifts take priority so subnormals settle at exponent 1
                    // with the lost bits folded into sticky.
                    if (|m_q[VEC_SIZE:NORM_POS+1] || e_q < 8'sd1) begin
                        m_q      <= m_q >> 1;
                        sticky_q <= sticky_q | m_q[0];
                        e_q      <= e_q + 8'sd1;
                    end else if (m_q == '0) begin
                        state_q <= ROUND;
                    end else if (!m_q[NORM_POS] && e_q > 8'sd1) begin
                        m_q <= m_q << 1;
                        e_q <= e_q - 8'sd1;
                    end else begin
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    result_q    <= r_res;
                    flags_q     <= {1'b0, r_flags};
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fma16_normround.sv
// tb_fma16_normround: scoreboard bench for the fma16 normalize/round back end.
module tb_fma16_normround;
    import fma16_pkg::*;

    localparam int VS = 43;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    fma16_normround_if #(.VEC_SIZE(VS)) bus();

    fma16_normround #(.VEC_SIZE(VS), .NORM_POS(30)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic [43:0] sm, input logic signed [7:0] e,
                        input logic s, input logic [1:0] rm, input logic sp, input logic [15:0] sres,
                        input logic [3:0] sfl, input logic [15:0] xres, input logic [3:0] xfl,
                        input int xlat, input int hold);
        exp_t x;
        int   lat;
        sb.push_back('{xres, xfl, xlat});
        bus.in_valid      = 1'b1;
        bus.sm            = sm;
        bus.e_in          = e;
        bus.sign_in       = s;
        bus.roundmode     = rm;
        bus.in_special    = sp;
        bus.special_res   = sres;
        bus.special_flags = sfl;
        bus.out_ready     = (hold == 0);
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.in_special = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) chk({tag, ".timeout"}, 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            chk({tag, ".hold_res"}, 32'(bus.result), 32'(xres));
            chk({tag, ".hold_rdy"}, 32'(bus.in_ready), 32'd0);
            chk({tag, ".hold_vld"}, 32'(bus.out_valid), 32'd1);
            bus.in_valid = 1'b1;
            bus.sm       = 44'd1 << 32;
            bus.e_in     = 8'sd15;
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        x = sb.pop_front();
        chk({tag, ".res"}, 32'(bus.result), 32'(x.res));
        chk({tag, ".flags"}, 32'(bus.flags), 32'(x.flg));
        chk({tag, ".lat"}, 32'(lat), 32'(x.lat));
        @(negedge clk);
        chk({tag, ".drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid      = 1'b0;
        bus.sm            = '0;
        bus.e_in          = '0;
        bus.sign_in       = 1'b0;
        bus.roundmode     = RZ;
        bus.in_special    = 1'b0;
        bus.special_res   = '0;
        bus.special_flags = '0;
        bus.out_ready     = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.rdy", 32'(bus.in_ready), 32'd1);
        chk("rst.vld", 32'(bus.out_valid), 32'd0);
        chk("rst.res", 32'(bus.result), 32'd0);
        chk("rst.flg", 32'(bus.flags), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        send("one",      44'd1 << 30, 8'sd15, 1'b0, RNE, 1'b0, 16'h0, 4'h0, 16'h3C00, 4'b0000, 3, 0);
        send("rshift2",  44'd1 << 32, 8'sd15, 1'b0, RNE, 1'b0, 16'h0, 4'h0, 16'h4400, 4'b0000, 5, 0);
        send("lshift2",  44'd1 << 28, 8'sd15, 1'b0, RNE, 1'b0, 16'h0, 4'h0, 16'h3400, 4'b0000, 5, 0);
        send("tie_rne",  (44'd1 << 30) | (44'd1 << 19), 8'sd15, 1'b0, RNE, 1'b0, 16'h0, 4'h0, 16'h3C00, 4'b0001, 3, 0);
        send("tie_rp",   (44'd1 << 30) | (44'd1 << 19), 8'sd15, 1'b0, RP,  1'b0, 16'h0, 4'h0, 16'h3C01, 4'b0001, 3, 0);
        send("tie_rz",   (44'd1 << 30) | (44'd1 << 19), 8'sd15, 1'b0, RZ,  1'b0, 16'h0, 4'h0, 16'h3C00, 4'b0001, 3, 0);
        send("tie_rmn",  (44'd1 << 30) | (44'd1 << 19), 8'sd15, 1'b1, RM,  1'b0, 16'h0, 4'h0, 16'hBC01, 4'b0001, 3, 0);
        send("of_rz",    44'd1 << 30, 8'sd31, 1'b0, RZ,  1'b0, 16'h0, 4'h0, 16'h7BFF, 4'b0101, 3, 0);
        send("of_rne",   44'd1 << 30, 8'sd31, 1'b0, RNE, 1'b0, 16'h0, 4'h0, 16'h7C00, 4'b0101, 3, 0);
        send("of_rpn",   44'd1 << 30, 8'sd31, 1'b1, RP,  1'b0, 16'h0, 4'h0, 16'hFBFF, 4'b0101, 3, 0);
        send("sub",      44'd1 << 30, -8'sd9, 1'b0, RNE, 1'b0, 16'h0, 4'h0, 16'h0001, 4'b0000, 13, 0);
        send("sub_nx",   (44'd1 << 30) | 44'd1, -8'sd9, 1'b0, RNE, 1'b0, 16'h0, 4'h0, 16'h0001, 4'b0011, 13, 0);
        send("zero",     44'd0, 8'sd15, 1'b1, RNE, 1'b0, 16'h0, 4'h0, 16'h8000, 4'b0000, 1, 0);
        send("special",  44'd1 << 30, 8'sd15, 1'b0, RNE, 1'b1, 16'h7E00, 4'b1000, 16'h7E00, 4'b1000, 1, 0);
        send("hold",     44'd1 << 30, 8'sd15, 1'b0, RNE, 1'b0, 16'h0, 4'h0, 16'h3C00, 4'b0000, 3, 5);

        bus.in_valid = 1'b1;
        bus.sm       = 44'd1 << 30;
        bus.e_in     = -8'sd9;
        bus.sign_in  = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst.vld", 32'(bus.out_valid), 32'd0);
        chk("midrst.rdy", 32'(bus.in_ready), 32'd1);
        chk("midrst.flg", 32'(bus.flags), 32'd0);
        chk("midrst.res", 32'(bus.result), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        send("after_rst", 44'd1 << 32, 8'sd15, 1'b0, RNE, 1'b0, 16'h0, 4'h0, 16'h4400, 4'b0000, 5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
